// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit drain.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Parity bit from the word's XOR reduction and the configured mode.
  function automatic logic parity_of(input logic xor_bit, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~xor_bit : xor_bit;
  endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
module baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q + CW'(1);
    if (clear || (count_q == LAST)) begin
      count_d = '0;
    end
  end

  // tick is registered so it lines up with count_q reaching LAST
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tick    <= 1'b0;
    end else begin
      count_q <= count_d;
      tick    <= (count_d == LAST);
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// Pops words from the FIFO and serialises each as a UART frame on tx.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             empty,
  output logic             read_request,
  input  logic [WIDTH-1:0] data_in,
  output logic             tx,
  output logic             busy
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic             par_q;
  logic             par_d;
  logic [BW-1:0]    bit_q;
  logic             tick;
  logic             baud_clear;
  logic             tx_d;
  logic             read_request_d;
  logic             busy_d;

  // Hold the baud timer at zero until the start bit begins.
  assign baud_clear = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable && !empty) begin
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD:  state_d = START;
      START: begin
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick && (bit_q == LAST_BIT)) begin
          state_d = (PARITY != PARITY_NONE) ? PAR : STOP;
        end
      end
      PAR: begin
        if (tick) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = (enable && !empty) ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Parity is latched from the captured word so later shifting cannot disturb it.
  always_comb begin
    shift_d = shift_q;
    par_d   = par_q;
    if (state_q == LOAD) begin
      shift_d = data_in;
      par_d   = parity_of(^data_in, PARITY);
    end else if ((state_q == DATA) && tick) begin
      shift_d = shift_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
    end else begin
      shift_q <= shift_d;
      par_q   <= par_d;
      if (state_q == START) begin
        bit_q <= '0;
      end else if ((state_q == DATA) && tick) begin
        bit_q <= (bit_q == LAST_BIT) ? '0 : bit_q + BW'(1);
      end
    end
  end

  // Outputs decoded from the next state so the registered pins track the state register.
  always_comb begin
    tx_d           = 1'b1;
    read_request_d = 1'b0;
    busy_d         = 1'b1;
    case (state_d)
      IDLE:    busy_d         = 1'b0;
      FETCH:   read_request_d = 1'b1;
      START:   tx_d           = 1'b0;
      DATA:    tx_d           = shift_d[0];
      PAR:     tx_d           = par_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx           <= 1'b1;
      read_request <= 1'b0;
      busy         <= 1'b0;
    end else begin
      tx           <= tx_d;
      read_request <= read_request_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Randomised self-checking bench: a behavioural FIFO feeds the drain; frames are checked bit by bit.
module tb_uart_tx_drain;

  localparam int unsigned W   = 8;
  localparam int unsigned CPB = 4;
  localparam int BOUND = 300;

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic         en0      = 1'b0;
  logic         en1      = 1'b0;
  logic         en2      = 1'b0;
  logic         empty0   = 1'b1;
  logic [W-1:0] din0     = '0;
  logic         empty_p  = 1'b0;
  logic [W-1:0] din_p    = 8'hA5;
  logic         push_req = 1'b0;
  logic [W-1:0] push_data = '0;
  logic         rr0, tx0, busy0;
  logic         rr1, tx1, busy1;
  logic         rr2, tx2, busy2;

  logic [W-1:0] fifo_q[$];
  int rr_cnt   = 0;
  int bad_pop  = 0;
  int rr1_cnt  = 0;
  int rr2_cnt  = 0;
  int busy_run = 0;
  int last_run = 0;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx_drain #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY(0)) u_dut0 (
    .clk(clk), .reset(reset), .enable(en0), .empty(empty0), .read_request(rr0),
    .data_in(din0), .tx(tx0), .busy(busy0)
  );
  uart_tx_drain #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY(1)) u_dut1 (
    .clk(clk), .reset(reset), .enable(en1), .empty(empty_p), .read_request(rr1),
    .data_in(din_p), .tx(tx1), .busy(busy1)
  );
  uart_tx_drain #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY(2)) u_dut2 (
    .clk(clk), .reset(reset), .enable(en2), .empty(empty_p), .read_request(rr2),
    .data_in(din_p), .tx(tx2), .busy(busy2)
  );

  // Registered FIFO model: pop on a sampled read_request, data valid the next cycle.
  always @(posedge clk) begin
    if (rr0) begin
      rr_cnt++;
      if (fifo_q.size() == 0) bad_pop++;
      else din0 <= fifo_q.pop_front();
    end
    if (push_req) fifo_q.push_back(push_data);
    empty0 <= (fifo_q.size() == 0);
    if (rr1) rr1_cnt++;
    if (rr2) rr2_cnt++;
  end

  always @(negedge clk) begin
    if (busy0) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected line level for bit slot k of a frame carrying w.
  function automatic logic model_bit(input logic [W-1:0] w, input int par, input int k);
    int ones;
    ones = $countones(w);
    if (k == 0) return 1'b0;
    if (k <= int'(W)) return w[k-1];
    if (par != 0 && k == int'(W) + 1) return ((ones % 2) == 1) ^ (par == 2);
    return 1'b1;
  endfunction

  function automatic logic tx_of(input int sel);
    case (sel)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  task automatic push(input logic [W-1:0] w);
    push_data = w;
    push_req  = 1'b1;
    @(negedge clk);
    push_req  = 1'b0;
  endtask

  // Waits for a start bit, then checks every cycle of the frame; gap = high cycles before it.
  task automatic check_frame(input int sel, input logic [W-1:0] w, input int par,
                             input int drop_at, output int gap);
    int nb;
    nb  = int'(W) + 2 + ((par != 0) ? 1 : 0);
    gap = 0;
    while (tx_of(sel) !== 1'b0 && gap < BOUND) begin
      @(negedge clk);
      gap++;
    end
    chk($sformatf("start[%0d] w=%02h", sel, w), tx_of(sel), 1'b0);
    if (tx_of(sel) !== 1'b0) return;
    for (int c = 0; c < nb * int'(CPB); c++) begin
      if (c == drop_at) en0 = 1'b0;
      chk($sformatf("tx[%0d] w=%02h c=%0d", sel, w, c), tx_of(sel), model_bit(w, par, c / int'(CPB)));
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int base;
    int n;
    logic [W-1:0] words [3];

    repeat (3) @(negedge clk);
    chk("reset_tx", tx0, 1'b1);
    chk("reset_busy", busy0, 1'b0);
    chk("reset_rr", rr0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // single frame, no parity
    en0 = 1'b1;
    push(8'hA5);
    check_frame(0, 8'hA5, 0, -1, gap);
    chk("a5_latency", gap, 3);
    repeat (3) @(negedge clk);
    chk("a5_busy_len", last_run, 42);
    chk("a5_pops", rr_cnt, 1);
    chk("a5_idle_tx", tx0, 1'b1);

    // parity variants
    en1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    check_frame(1, 8'hA5, 1, -1, gap);
    en2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    check_frame(2, 8'hA5, 2, -1, gap);
    repeat (3) @(negedge clk);
    chk("even_pops", rr1_cnt, 1);
    chk("odd_pops", rr2_cnt, 1);
    chk("even_busy", busy1, 1'b0);
    chk("odd_busy", busy2, 1'b0);

    // back-to-back drain
    base = rr_cnt;
    push(8'h01);
    push(8'hFF);
    push(8'h3C);
    check_frame(0, 8'h01, 0, -1, gap);
    check_frame(0, 8'hFF, 0, -1, gap);
    chk("b2b_gap1", gap, 2);
    check_frame(0, 8'h3C, 0, -1, gap);
    chk("b2b_gap2", gap, 2);
    repeat (5) @(negedge clk);
    chk("b2b_pops", rr_cnt - base, 3);
    chk("b2b_fifo_empty", fifo_q.size(), 0);
    chk("b2b_busy", busy0, 1'b0);

    // empty FIFO with enable high
    base = rr_cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk($sformatf("empty_idle c=%0d", i), {rr0, tx0, busy0}, 3'b010);
    end
    chk("empty_no_pop", rr_cnt, base);

    // enable gating and mid-frame enable drop
    en0  = 1'b0;
    base = rr_cnt;
    push(8'h55);
    push(8'h66);
    repeat (10) @(negedge clk);
    chk("en_off_no_pop", rr_cnt, base);
    chk("en_off_tx", tx0, 1'b1);
    chk("en_off_busy", busy0, 1'b0);
    en0 = 1'b1;
    check_frame(0, 8'h55, 0, int'(3 * CPB), gap);
    chk("en_latency", gap, 3);
    repeat (20) @(negedge clk);
    chk("en_drop_pops", rr_cnt - base, 1);
    chk("en_drop_busy", busy0, 1'b0);
    chk("en_drop_queued", fifo_q.size(), 1);
    en0 = 1'b1;
    check_frame(0, 8'h66, 0, -1, gap);
    chk("en_resume_latency", gap, 3);

    // reset during the third data bit
    push(8'hC3);
    gap = 0;
    while (tx0 !== 1'b0 && gap < BOUND) begin
      @(negedge clk);
      gap++;
    end
    chk("rst_frame_start", tx0, 1'b0);
    repeat (3 * CPB + 1) @(negedge clk);
    chk("rst_pre_bit2", tx0, model_bit(8'hC3, 0, 3));
    reset = 1'b1;
    #1;
    chk("rst_async_tx", tx0, 1'b1);
    chk("rst_async_busy", busy0, 1'b0);
    chk("rst_async_rr", rr0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    base  = rr_cnt;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk($sformatf("rst_idle c=%0d", i), {rr0, tx0, busy0}, 3'b010);
    end
    chk("rst_no_pop", rr_cnt, base);
    push(8'h5A);
    check_frame(0, 8'h5A, 0, -1, gap);
    chk("rst_new_latency", gap, 3);

    // random bursts
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(0, 10)) @(negedge clk);
      base = rr_cnt;
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) begin
        words[i] = W'($urandom);
        push(words[i]);
      end
      for (int i = 0; i < n; i++) begin
        check_frame(0, words[i], 0, -1, gap);
        if (i > 0) chk($sformatf("rnd_gap it=%0d i=%0d", it, i), gap, 2);
      end
      repeat (3) @(negedge clk);
      chk($sformatf("rnd_pops it=%0d", it), rr_cnt - base, n);
      chk($sformatf("rnd_busy it=%0d", it), busy0, 1'b0);
    end

    chk("no_pop_while_empty", bad_pop, 0);
    chk("final_fifo_empty", fifo_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
